// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and legal width range.
package serial_subtractor_pkg;

    // Operand width limits the datapath is built and characterised for.
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when a requested width is inside the supported range.
    function automatic logic width_is_legal(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor_1b (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy_diff;

    // Difference bit and borrow-out from the shared x^y term.
    always_comb begin
        w_xy_diff = x ^ y;
        d         = w_xy_diff ^ bin;
        bout      = (~x & y) | (~w_xy_diff & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, one bit per enabled clock, LSB first.
// Operands are accepted in IDLE, shifted through a single full-subtractor cell in SHIFT,
// and the result is held in DONE until the consumer takes it.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Width legality is a static property of the instance; tie it to a constant so an
    // illegal WIDTH shows up as a permanently deasserted in_ready rather than bad results.
    localparam logic WIDTH_OK = width_is_legal(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_bor;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;
    logic             w_release;
    logic [WIDTH-1:0] w_diff_final;

    // The single arithmetic cell, fed from the operand LSBs and the registered borrow.
    full_subtractor_1b u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_bor),
        .d    (w_d),
        .bout (w_bout)
    );

    // Handshake qualifiers and the fully assembled difference on the final bit.
    always_comb begin
        w_last       = (r_state == SHIFT) && (r_cnt == CNT_LAST);
        w_accept     = (r_state == IDLE) && in_valid && WIDTH_OK;
        w_release    = (r_state == DONE) && r_out_valid && out_ready;
        w_diff_final = {w_d, r_diff_sr[WIDTH-1:1]};
    end

    // Control FSM: IDLE -> SHIFT on accept, SHIFT -> DONE on last bit, DONE -> IDLE on take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (ena) begin
            case (r_state)
                IDLE:    if (w_accept)  r_state <= SHIFT;
                SHIFT:   if (w_last)    r_state <= DONE;
                DONE:    if (w_release) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand and partial-difference shift registers plus operand sign capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
        end else if (ena) begin
            if (w_accept) begin
                r_a_sr  <= a;
                r_b_sr  <= b;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end else if (r_state == SHIFT) begin
                r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
                r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
                r_diff_sr <= w_diff_final;
            end
        end
    end

    // Bit counter and running borrow; counter wraps to 0 on the last bit so it never
    // exceeds WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_bor <= 1'b0;
        end else if (ena) begin
            if (w_accept) begin
                r_cnt <= '0;
                r_bor <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_bor <= w_bout;
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // Result registers: written only on the last bit, held through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (ena && w_last) begin
            r_diff   <= w_diff_final;
            r_borrow <= w_bout;
            // Signed overflow: operands differ in sign and the result sign differs from A.
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    // Result-valid flag: cleared on a new load or when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (ena) begin
            if (w_accept || w_release) begin
                r_out_valid <= 1'b0;
            end else if (w_last) begin
                r_out_valid <= 1'b1;
            end
        end
    end

    // Status outputs decoded straight from state; results driven from their registers.
    always_comb begin
        in_ready  = (r_state == IDLE) && WIDTH_OK;
        busy      = (r_state == SHIFT);
        out_valid = r_out_valid;
        diff      = r_diff;
        borrow    = r_borrow;
        overflow  = r_ovf;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         busy;

    int n_tests;
    int n_fail;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one edge; caller is at posedge+1. Returns after accept edge+1.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid; optional 3-cycle ena gap after edge 3.
    task automatic wait_done(input bit gap, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            if (gap && cycles == 3) ena = 1'b0;
            if (gap && cycles == 6) ena = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        ena = 1'b1;
    endtask

    // Let the consumer take the result (out_ready assumed high).
    task automatic drain();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({in_ready, out_valid, busy, borrow, overflow} !== 5'b10000) begin
            $display("FAIL reset_flags: got %b want 10000",
                     {in_ready, out_valid, busy, borrow, overflow});
            n_fail++;
        end
        n_tests++;
        if (diff !== 8'h00) begin
            $display("FAIL reset_diff: got %h want 00", diff);
            n_fail++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic [W-1:0] exp_d,
                                 input logic exp_b, input logic exp_o);
        int cyc;
        start_op(av, bv);
        wait_done(1'b0, cyc);
        n_tests++;
        if (cyc !== W) begin
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, W);
            n_fail++;
        end
        n_tests++;
        if ({diff, borrow, overflow} !== {exp_d, exp_b, exp_o}) begin
            $display("FAIL %s_result: got d=%h b=%b o=%b want d=%h b=%b o=%b",
                     name, diff, borrow, overflow, exp_d, exp_b, exp_o);
            n_fail++;
        end
        drain();
    endtask

    task automatic test_basic();
        int cyc;
        start_op(8'd200, 8'd55);
        n_tests++;
        if ({busy, in_ready} !== 2'b10) begin
            $display("FAIL basic_busy: got busy/in_ready=%b want 10", {busy, in_ready});
            n_fail++;
        end
        wait_done(1'b0, cyc);
        n_tests++;
        if (cyc !== W) begin
            $display("FAIL basic_latency: got %0d want %0d", cyc, W);
            n_fail++;
        end
        n_tests++;
        if ({diff, borrow, overflow, busy} !== {8'd145, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL basic_result: got d=%0d b=%b o=%b busy=%b want d=145 b=0 o=0 busy=0",
                     diff, borrow, overflow, busy);
            n_fail++;
        end
        drain();
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL basic_release: got in_ready/out_valid=%b want 10",
                     {in_ready, out_valid});
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        run_and_check("wrap_5m7", 8'd5, 8'd7, 8'hFE, 1'b1, 1'b0);
        run_and_check("wrap_same", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        run_and_check("ovf_80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_and_check("ovf_7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        out_ready = 1'b0;
        start_op(8'd10, 8'd3);
        wait_done(1'b0, cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            a        = 8'd1;
            b        = 8'd1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if ({out_valid, in_ready, busy} !== 3'b100 || diff !== 8'd7) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d cycles wrong, last ov/ir/busy=%b d=%0d want 100 d=7",
                     bad, {out_valid, in_ready, busy}, diff);
            n_fail++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10 || diff !== 8'd7) begin
            $display("FAIL bp_release: got ir/ov=%b d=%0d want 10 d=7",
                     {in_ready, out_valid}, diff);
            n_fail++;
        end
        run_and_check("bp_next", 8'd20, 8'd6, 8'd14, 1'b0, 1'b0);
    endtask

    task automatic test_ena_gap();
        int cyc;
        start_op(8'd100, 8'd30);
        wait_done(1'b1, cyc);
        n_tests++;
        if (cyc !== W + 3) begin
            $display("FAIL ena_latency: got %0d want %0d", cyc, W + 3);
            n_fail++;
        end
        n_tests++;
        if ({diff, borrow, overflow} !== {8'd70, 1'b0, 1'b0}) begin
            $display("FAIL ena_result: got d=%0d b=%b o=%b want d=70 b=0 o=0",
                     diff, borrow, overflow);
            n_fail++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        start_op(8'd200, 8'd55);
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, busy, in_ready, borrow, overflow} !== 5'b00100 || diff !== 8'h00) begin
            $display("FAIL rstmid_outputs: got ov/busy/ir/b/o=%b d=%h want 00100 d=00",
                     {out_valid, busy, in_ready, borrow, overflow}, diff);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL rstmid_release: got ir/ov=%b want 10", {in_ready, out_valid});
            n_fail++;
        end
        run_and_check("rstmid_fresh", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_wrap();
        test_overflow();
        test_backpressure();
        test_ena_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
